demux_1t5_hs: RTL and testbench
===============================

# demux_1t5_hs

Registered 1-to-5 demultiplexer with valid/ready handshaking. It is the distribution counterpart of the ALU-side 5:1 select mux. A single producer presents a word plus a 3-bit destination select. The block captures the word into a one-entry holding register and delivers it to exactly one of five consumer channels. Out-of-range selects are accepted, dropped and counted, so a bad decode never stalls the datapath.

## Interface
- `n`, default 8, data width of the input word and of each output channel.
- `CLK` input 1: rising-edge clock; only clock in the block.
- `RST` input 1: synchronous, active-high reset, sampled on the `CLK` rising edge.
- `SEL` input 3: destination channel for the offered word. Values 0–4 are valid; 5–7 are invalid.
- `D_IN` input n: offered data word.
- `IN_VALID` input 1: producer offers `SEL`/`D_IN` this cycle.
- `IN_READY` output 1: the block accepts the offer this cycle. A transfer occurs when `IN_VALID && IN_READY`.
- `OUT_VALID` output 5: one-hot; bit k set means channel k holds a word.
- `OUT_READY` input 5: bit k set means consumer k takes the word this cycle.
- `D0`..`D4` outputs, n each: channel data. The held word appears on the selected channel; all other channels read 0.
- `ERR` output 1: one-cycle pulse, the cycle after an invalid-`SEL` word is accepted.
- `ERR_CNT` output 8: saturating count of dropped invalid-`SEL` words.

## Operation
- **FSM states:**
  - `IDLE`: holding register empty.
  - `HOLD`: register holds `data_q` and `sel_q`, with `sel_q` always 0–4.
- **Accept condition:** `IN_READY = (state==IDLE) || (state==HOLD && OUT_READY[sel_q])`. This is combinational from `OUT_READY` and registered state only; it never depends on `IN_VALID`.
- **Drain condition:** `HOLD && OUT_READY[sel_q]`. The consumer takes `data_q` that cycle.
- **Transitions on each rising edge (priority order):**
  - `RST` → `IDLE`.
  - Transfer with valid `SEL` → `HOLD`, capture `D_IN` and `SEL`. This covers both the `IDLE` case and the drain-plus-accept case in the same cycle.
  - Transfer with invalid `SEL` → `IDLE`. Nothing is stored, `ERR` is set for one cycle, and `ERR_CNT` increments unless it is already 255.
  - Drain without transfer → `IDLE`.
  - Otherwise the block holds its state.
- **Outputs in `HOLD`:**
  - `OUT_VALID = 1 << sel_q`.
  - `D[sel_q] = data_q`; all other `D` channels are 0.
- **Outputs in `IDLE`:** `OUT_VALID = 0` and all `D` channels are 0.
- **Stability while stalled:** in `HOLD` with `OUT_READY[sel_q]=0`, `data_q`, `sel_q` and `OUT_VALID` stay stable. `OUT_READY` bits of non-selected channels are ignored.
- **Saturation:** `ERR_CNT` saturates at 8'hFF, where it holds. `ERR` still pulses on every drop.

## Timing
- **Reset values:** `OUT_VALID=0`, `D0`..`D4=0`, `ERR=0`, `ERR_CNT=0`, state `IDLE`. `IN_READY=1` in the first cycle after reset.
- **Latency:** a word accepted at edge t is on `OUT_VALID`/`D[k]` immediately after t, i.e. one cycle.
- **Throughput:** with `OUT_READY` held high, one word per cycle (back-to-back drain and accept).
- **Reset while in `HOLD`:** the held word is discarded without a drain, and `ERR_CNT` clears.
- **Invalid `SEL` during a drain:** the drain completes, the invalid word is dropped, and the next state is `IDLE`.
- **`ERR` timing:** `ERR` is registered and is never asserted in the same cycle as the offending transfer.

## Structure
- **Shared package** `demux_pkg` contains:
  - `NCH=5`.
  - `SEL_W=3`.
  - The state enum `{IDLE, HOLD}`.
  - Function `sel_valid(sel)` returning `sel < NCH`.
- **Sub-module** `sat_cnt_8`: 8-bit saturating counter with synchronous active-high clear and an increment-enable input. It is instantiated once, for `ERR_CNT`.
- **Top-level contents:** the FSM, the holding registers and the output decode. The output decode is a generate loop over `NCH`.

## Test plan
- **Reset:** hold `RST` for 2 cycles → `OUT_VALID=5'b00000`, all `D`=0, `ERR_CNT=0`, `IN_READY=1`.
- **Single transfer:** `SEL=3`, `D_IN=8'hA5`, `IN_VALID=1` for one cycle, with `OUT_READY=0` →
  - Next cycle: `OUT_VALID=5'b01000`, `D3=8'hA5`, other `D`=0, `IN_READY=0`.
  - Raise `OUT_READY[3]` → the following cycle has `OUT_VALID=0`.
- **Back-to-back streaming:** stream 8'h01..8'h05 to channels 0..4 with `OUT_READY=5'b11111` → each word appears on its channel exactly one cycle after acceptance, `IN_READY` stays 1 throughout, and no bubbles occur.
- **Stall behaviour:** hold a word for channel 1 and raise `OUT_READY[2]` only → the word persists, `IN_READY=0`, and a new offer is not accepted until `OUT_READY[1]=1`.
- **Invalid selects:** offer `SEL=6` 300 times → no `OUT_VALID`, `ERR` pulses 300 times, and `ERR_CNT` ends at 8'hFF.
- **Reset while holding:** in `HOLD` with `D2=8'h3C`, assert `RST` → next cycle `OUT_VALID=0`, `D2=0`, `ERR_CNT=0`.

Source files
------------

// File: rtl/demux_pkg.sv
// Shared types and helpers for the 1-to-5 handshaked demultiplexer.
package demux_pkg;

    localparam int NCH   = 5;
    localparam int SEL_W = 3;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_e;

    function automatic logic sel_valid(input logic [SEL_W-1:0] sel);
        return sel < SEL_W'(NCH);
    endfunction

endpackage

// File: rtl/demux_1t5_hs_sat_cnt_8.sv
// 8-bit saturating up-counter with synchronous clear; holds at 8'hFF.
module sat_cnt_8 (
    input  logic       clk,
    input  logic       clr,
    input  logic       inc,
    output logic [7:0] cnt
);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != 8'hFF)) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/demux_1t5_hs.sv
// Registered 1-to-5 demux with valid/ready handshake; invalid selects are dropped and counted.
//   state | meaning
//   IDLE  | holding register empty, always ready
//   HOLD  | data_q/sel_q valid, sel_q in 0..4, waiting for OUT_READY[sel_q]
module demux_1t5_hs
    import demux_pkg::*;
#(
    parameter int n = 8
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic [2:0]   SEL,
    input  logic [n-1:0] D_IN,
    input  logic         IN_VALID,
    output logic         IN_READY,
    output logic [4:0]   OUT_VALID,
    input  logic [4:0]   OUT_READY,
    output logic [n-1:0] D0,
    output logic [n-1:0] D1,
    output logic [n-1:0] D2,
    output logic [n-1:0] D3,
    output logic [n-1:0] D4,
    output logic         ERR,
    output logic [7:0]   ERR_CNT
);

    state_e             state_q, state_d;
    logic [n-1:0]       data_q,  data_d;
    logic [SEL_W-1:0]   sel_q,   sel_d;
    logic               err_q,   err_d;

    logic               drain;
    logic               xfer;
    logic               drop;
    logic [n-1:0]       d_ch [NCH];

    // Ready depends only on registered state and the selected consumer's ready.
    assign drain    = (state_q == HOLD) && OUT_READY[sel_q];
    assign IN_READY = (state_q == IDLE) || drain;
    assign xfer     = IN_VALID && IN_READY;

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        sel_d   = sel_q;
        err_d   = 1'b0;
        drop    = 1'b0;
        if (xfer && sel_valid(SEL)) begin
            state_d = HOLD;
            data_d  = D_IN;
            sel_d   = SEL;
        end else if (xfer) begin
            state_d = IDLE;
            err_d   = 1'b1;
            drop    = 1'b1;
        end else if (drain) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            data_q  <= '0;
            sel_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            sel_q   <= sel_d;
            err_q   <= err_d;
        end
    end

    sat_cnt_8 u_err_cnt (
        .clk (CLK),
        .clr (RST),
        .inc (drop),
        .cnt (ERR_CNT)
    );

    for (genvar k = 0; k < NCH; k++) begin : g_ch
        assign OUT_VALID[k] = (state_q == HOLD) && (sel_q == SEL_W'(k));
        assign d_ch[k]      = OUT_VALID[k] ? data_q : '0;
    end

    assign D0  = d_ch[0];
    assign D1  = d_ch[1];
    assign D2  = d_ch[2];
    assign D3  = d_ch[3];
    assign D4  = d_ch[4];
    assign ERR = err_q;

endmodule

// File: tb/tb_demux_1t5_hs.sv
// Directed self-checking bench for demux_1t5_hs.
module tb_demux_1t5_hs;

    logic       CLK = 1'b0;
    logic       RST;
    logic [2:0] SEL;
    logic [7:0] D_IN;
    logic       IN_VALID;
    logic       IN_READY;
    logic [4:0] OUT_VALID;
    logic [4:0] OUT_READY;
    logic [7:0] D0, D1, D2, D3, D4;
    logic       ERR;
    logic [7:0] ERR_CNT;
    logic [7:0] d_arr [5];

    int passed = 0;
    int total  = 0;
    int err_pulses;
    int ov_bad;

    always #5 CLK = ~CLK;

    demux_1t5_hs #(.n(8)) dut (
        .CLK(CLK), .RST(RST), .SEL(SEL), .D_IN(D_IN), .IN_VALID(IN_VALID),
        .IN_READY(IN_READY), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
        .D0(D0), .D1(D1), .D2(D2), .D3(D3), .D4(D4), .ERR(ERR), .ERR_CNT(ERR_CNT)
    );

    assign d_arr[0] = D0;
    assign d_arr[1] = D1;
    assign d_arr[2] = D2;
    assign d_arr[3] = D3;
    assign d_arr[4] = D4;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    initial begin
        RST = 1'b1; SEL = 3'd0; D_IN = 8'h00; IN_VALID = 1'b0; OUT_READY = 5'b00000;
        tick(); tick();
        RST = 1'b0; #1;
        chk("rst_out_valid", 32'(OUT_VALID), 32'(5'b00000));
        chk("rst_d_or", 32'(D0 | D1 | D2 | D3 | D4), 32'(8'h00));
        chk("rst_err_cnt", 32'(ERR_CNT), 32'(8'h00));
        chk("rst_err", 32'(ERR), 32'(1'b0));
        chk("rst_in_ready", 32'(IN_READY), 32'(1'b1));

        // single transfer into channel 3 with consumer stalled
        SEL = 3'd3; D_IN = 8'hA5; IN_VALID = 1'b1;
        tick();
        IN_VALID = 1'b0; #1;
        chk("single_out_valid", 32'(OUT_VALID), 32'(5'b01000));
        chk("single_d3", 32'(D3), 32'(8'hA5));
        chk("single_others", 32'(D0 | D1 | D2 | D4), 32'(8'h00));
        chk("single_in_ready", 32'(IN_READY), 32'(1'b0));
        chk("single_err", 32'(ERR), 32'(1'b0));
        OUT_READY = 5'b01000; #1;
        chk("single_ready_on_drain", 32'(IN_READY), 32'(1'b1));
        tick();
        chk("single_drained", 32'(OUT_VALID), 32'(5'b00000));

        // back-to-back streaming, one word per cycle
        OUT_READY = 5'b11111;
        for (int i = 0; i < 5; i++) begin
            SEL = 3'(i); D_IN = 8'(i + 1); IN_VALID = 1'b1; #1;
            chk($sformatf("stream_in_ready_%0d", i), 32'(IN_READY), 32'(1'b1));
            tick();
            chk($sformatf("stream_valid_%0d", i), 32'(OUT_VALID), 32'(5'b00001 << i));
            chk($sformatf("stream_data_%0d", i), 32'(d_arr[i]), 32'(i + 1));
        end
        IN_VALID = 1'b0;
        tick();
        chk("stream_empty", 32'(OUT_VALID), 32'(5'b00000));

        // stall: word for channel 1, only non-selected ready asserted
        OUT_READY = 5'b00000; SEL = 3'd1; D_IN = 8'h5A; IN_VALID = 1'b1;
        tick();
        chk("stall_captured", 32'(OUT_VALID), 32'(5'b00010));
        SEL = 3'd4; D_IN = 8'h77; OUT_READY = 5'b00100; #1;
        chk("stall_in_ready", 32'(IN_READY), 32'(1'b0));
        tick();
        chk("stall_valid_held", 32'(OUT_VALID), 32'(5'b00010));
        chk("stall_d1_held", 32'(D1), 32'(8'h5A));
        chk("stall_d4_zero", 32'(D4), 32'(8'h00));
        OUT_READY = 5'b00010; #1;
        chk("stall_release_ready", 32'(IN_READY), 32'(1'b1));
        tick();
        chk("stall_next_valid", 32'(OUT_VALID), 32'(5'b10000));
        chk("stall_next_d4", 32'(D4), 32'(8'h77));
        chk("stall_next_d1", 32'(D1), 32'(8'h00));
        IN_VALID = 1'b0; OUT_READY = 5'b10000;
        tick();
        chk("stall_empty", 32'(OUT_VALID), 32'(5'b00000));

        // 300 invalid selects: every one dropped and pulsed, counter saturates
        OUT_READY = 5'b00000; SEL = 3'd6; D_IN = 8'hEE; IN_VALID = 1'b1;
        err_pulses = 0; ov_bad = 0;
        #1;
        chk("inv_err_not_same_cycle", 32'(ERR), 32'(1'b0));
        for (int i = 0; i < 300; i++) begin
            tick();
            if (ERR === 1'b1) err_pulses++;
            if (OUT_VALID !== 5'b00000) ov_bad++;
            if (i == 253) chk("inv_cnt_fe", 32'(ERR_CNT), 32'(8'hFE));
            if (i == 254) chk("inv_cnt_ff", 32'(ERR_CNT), 32'(8'hFF));
        end
        IN_VALID = 1'b0;
        tick();
        chk("inv_err_pulses", 32'(err_pulses), 32'(300));
        chk("inv_no_out_valid", 32'(ov_bad), 32'(0));
        chk("inv_cnt_sat", 32'(ERR_CNT), 32'(8'hFF));
        chk("inv_err_cleared", 32'(ERR), 32'(1'b0));

        // invalid select arriving during a drain
        SEL = 3'd0; D_IN = 8'h11; IN_VALID = 1'b1;
        tick();
        SEL = 3'd7; D_IN = 8'h22; OUT_READY = 5'b00001;
        tick();
        IN_VALID = 1'b0; OUT_READY = 5'b00000; #1;
        chk("drain_inv_valid", 32'(OUT_VALID), 32'(5'b00000));
        chk("drain_inv_err", 32'(ERR), 32'(1'b1));
        chk("drain_inv_cnt", 32'(ERR_CNT), 32'(8'hFF));

        // reset while holding
        SEL = 3'd2; D_IN = 8'h3C; IN_VALID = 1'b1;
        tick();
        IN_VALID = 1'b0; #1;
        chk("hold_d2", 32'(D2), 32'(8'h3C));
        RST = 1'b1;
        tick();
        RST = 1'b0; #1;
        chk("rsthold_valid", 32'(OUT_VALID), 32'(5'b00000));
        chk("rsthold_d2", 32'(D2), 32'(8'h00));
        chk("rsthold_cnt", 32'(ERR_CNT), 32'(8'h00));
        chk("rsthold_in_ready", 32'(IN_READY), 32'(1'b1));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
